// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 raster geometry and the coordinate type used by every sprite stage.
// Pure declarations: no logic, no timing.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, display-enable, syncs and frame strobes.
// master = timing generator, slave = renderer stages consuming the raster.
interface vga_timing_gen_if #(
    parameter int FCNT_W = 8
) ();
    import vga_pkg::*;

    coord_t              DrawX;
    coord_t              DrawY;
    logic                blank;
    logic                hs;
    logic                vs;
    logic                frame_start;
    logic [FCNT_W-1:0]   frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_sync_window.sv
// Half-open range test lo <= value < hi, shared by the hs, vs and blank decodes.
// Purely combinational; no state, no backpressure.
module sync_window
    import vga_pkg::*;
(
    input  coord_t lo,
    input  coord_t hi,
    input  coord_t value,
    output logic   in_range
);

    assign in_range = (value >= lo) && (value < hi);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: cascaded H/V counters with every output registered.
// Outputs describe the pixel held in DrawX/DrawY; no backpressure, advances every pixel clock.
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int FCNT_W    = 8
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    vga_timing_gen_if.master        vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam vga_pkg::coord_t H_LAST = vga_pkg::coord_t'(H_TOTAL - 1);
    localparam vga_pkg::coord_t V_LAST = vga_pkg::coord_t'(V_TOTAL - 1);
    localparam vga_pkg::coord_t H_VIS  = vga_pkg::coord_t'(H_VISIBLE);
    localparam vga_pkg::coord_t V_VIS  = vga_pkg::coord_t'(V_VISIBLE);
    localparam vga_pkg::coord_t HS_LO  = vga_pkg::coord_t'(H_VISIBLE + H_FRONT);
    localparam vga_pkg::coord_t HS_HI  = vga_pkg::coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam vga_pkg::coord_t VS_LO  = vga_pkg::coord_t'(V_VISIBLE + V_FRONT);
    localparam vga_pkg::coord_t VS_HI  = vga_pkg::coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [FCNT_W-1:0] FC_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    vga_pkg::coord_t x_nxt;
    vga_pkg::coord_t y_nxt;
    logic            frame_wrap;
    logic            hs_win;
    logic            vs_win;
    logic            h_vis;
    logic            v_vis;

    always_comb begin
        x_nxt = vga.DrawX + vga_pkg::coord_t'(1);
        y_nxt = vga.DrawY;
        if (vga.DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (vga.DrawY == V_LAST) ? '0 : vga.DrawY + vga_pkg::coord_t'(1);
        end
    end

    // Reset parks the raster at (0,0) with frame_start low, so the first frame never strobes.
    assign frame_wrap = (x_nxt == '0) && (y_nxt == '0);

    // Decodes look at the next position so the registered flags line up with DrawX/DrawY.
    sync_window u_hs_win (.lo(HS_LO), .hi(HS_HI), .value(x_nxt), .in_range(hs_win));
    sync_window u_vs_win (.lo(VS_LO), .hi(VS_HI), .value(y_nxt), .in_range(vs_win));
    sync_window u_h_vis  (.lo('0),    .hi(H_VIS), .value(x_nxt), .in_range(h_vis));
    sync_window u_v_vis  (.lo('0),    .hi(V_VIS), .value(y_nxt), .in_range(v_vis));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vga.DrawX       <= '0;
            vga.DrawY       <= '0;
            vga.blank       <= 1'b0;
            vga.hs          <= 1'b1;
            vga.vs          <= 1'b1;
            vga.frame_start <= 1'b0;
            vga.frame_count <= '0;
        end else begin
            vga.DrawX       <= x_nxt;
            vga.DrawY       <= y_nxt;
            vga.blank       <= h_vis && v_vis;
            vga.hs          <= ~hs_win;
            vga.vs          <= ~vs_win;
            vga.frame_start <= frame_wrap;
            if (frame_wrap) begin
                vga.frame_count <= vga.frame_count + FC_ONE;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing: pixel coordinates, display-enable, syncs and frame strobes.
- Sits directly upstream of every sprite/background renderer. Its DrawX, DrawY and blank outputs drive those stages; blank is active-high display-enable.
- Also provides a frame-start pulse and a free-running frame counter that sprite stages use for animation.
- Runs entirely in the 25 MHz pixel-clock domain.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- FCNT_W, 8, width of frame_count

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 = inside visible area (DrawX<H_VISIBLE and DrawY<V_VISIBLE)
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse when the position becomes (0,0)
- frame_count  out  FCNT_W  frames completed since reset, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
- All outputs are flops; none are combinational from the counters. Every output describes the same pixel as DrawX/DrawY in the same cycle.
- Reset, asserted asynchronously and immediately on reset_n low:
  - DrawX=0, DrawY=0, frame_count=0
  - hs=1, vs=1
  - blank=0, frame_start=0
- First posedge after reset_n rises: DrawX=1, DrawY=0, blank=1.
  - Pixel (0,0) of the first frame is forced dark.
  - No frame_start is issued for the first frame.
- Horizontal counter, per posedge:
  - DrawX increments by 1.
  - At DrawX==H_TOTAL-1, the next value is 0.
- Vertical counter:
  - DrawY increments only when DrawX wraps.
  - When DrawX wraps with DrawY==V_TOTAL-1, the next DrawY is 0.
- Output decode, computed from the next counter values and registered:
  - hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - vs is line-granular: it changes only at DrawX=0 boundaries.
  - blank=1 iff DrawX<640 and DrawY<480.
- frame_start = 1 for exactly the cycle where (DrawX,DrawY)=(0,0), excluding the post-reset cycle. Period is 420000 cycles.
- frame_count increments by 1 in the same cycle frame_start is 1, so it shows the new value from (0,0) onward. It wraps 2^FCNT_W-1 -> 0 silently.
- Reset asserted mid-frame: all outputs return to their reset values immediately. Counting restarts from (0,0) per the first-edge rule above. No partial sync pulses are extended.
- No other state machine; the two cascaded counters are the only state besides frame_count.

Decomposition:
- Package vga_pkg holds:
  - localparams H_VISIBLE..V_BACK, H_TOTAL, V_TOTAL
  - a 10-bit coordinate typedef, used by all sprite stages
- The block itself has no sub-modules; the H/V counters are inline.
- Optional sub-module: sync_window (lo, hi, value -> in-range flag), shared by the hs, vs and blank decodes.

Test Plan:
- Hold reset_n=0 for 5 cycles, then release -> during reset all outputs are at reset values. First edge gives DrawX=1, DrawY=0, blank=1, hs=1, vs=1, frame_start=0.
- Run one full line -> hs low for exactly 96 consecutive cycles, DrawX 656..751. blank high exactly for DrawX 0..639 on lines 0..479. DrawX wraps 799->0 while DrawY increments.
- Run two full frames -> frame_start pulses are exactly 420000 cycles apart. vs low for exactly 1600 cycles covering DrawY 490..491. blank=0 on every pixel with DrawY>=480.
- Run 256 frames with FCNT_W=8 -> frame_count steps 1,2,...,255,0, each change coincident with frame_start.
- Assert reset_n=0 asynchronously (between edges) at DrawX=700, DrawY=491, with hs=0 and vs=0 -> hs, vs, blank, DrawX, DrawY and frame_count take reset values before the next posedge. Counting restarts correctly after release.
- Probe DrawX=799, DrawY=524 -> the next cycle gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count incremented.
